// File: rtl/spif_pkt_pkg.sv
// Shared defaults and output-register state type for the SPIF packet path.
package spif_pkt_pkg;

  localparam int unsigned PacketBitsDefault = 72;
  localparam int unsigned NumInputsDefault  = 4;

  typedef enum logic [0:0] {
    OutEmpty = 1'b0,
    OutFull  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above ptr, wrapping to 0.
module rr_arbiter
  import spif_pkt_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = NumInputsDefault,
  localparam int unsigned PtrW = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] vld,
  input  logic [PtrW-1:0]       ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [PtrW-1:0]       grant_idx,
  output logic                  any_vld
);

  logic [PtrW-1:0] j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_vld   = 1'b0;
    j         = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      j = PtrW'((32'(ptr) + k) % NUM_INPUTS);
      if (!any_vld && vld[j]) begin
        any_vld   = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = j;
      end
    end
  end

endmodule

// File: rtl/pkt_arbiter.sv
// N-to-1 packet arbiter with a single output register, stall-timeout drop and
// delivered/dropped counters.
module pkt_arbiter
  import spif_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS = PacketBitsDefault,
  parameter int unsigned NUM_INPUTS  = NumInputsDefault
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       drop_wait_in,
  input  logic [NUM_INPUTS*PACKET_BITS-1:0] pkt_in_data_in,
  input  logic [NUM_INPUTS-1:0]             pkt_in_vld_in,
  output logic [NUM_INPUTS-1:0]             pkt_in_rdy_out,
  output logic [PACKET_BITS-1:0]            pkt_out_data_out,
  output logic                              pkt_out_vld_out,
  input  logic                              pkt_out_rdy_in,
  output logic [31:0]                       fwd_cnt_out,
  output logic [31:0]                       drop_cnt_out
);

  localparam int unsigned PtrW = $clog2(NUM_INPUTS);

  out_state_e             state_q, state_d;
  logic [PACKET_BITS-1:0] data_q, data_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [31:0]            wait_q, wait_d;
  logic [31:0]            fwd_q, fwd_d;
  logic [31:0]            drop_q, drop_d;

  logic [NUM_INPUTS-1:0]  grant;
  logic [PtrW-1:0]        grant_idx;
  logic                   any_vld;
  logic [PACKET_BITS-1:0] sel_data;
  logic                   full, deliver, drop_now, reg_free, accept;

  rr_arbiter #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_rr_arbiter (
    .vld      (pkt_in_vld_in),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_vld  (any_vld)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) sel_data = pkt_in_data_in[i*PACKET_BITS +: PACKET_BITS];
    end
  end

  // Delivery wins over timeout when both would fire in the same cycle.
  assign full     = (state_q == OutFull);
  assign deliver  = full && pkt_out_rdy_in;
  assign drop_now = full && !pkt_out_rdy_in && (drop_wait_in != 32'd0) &&
                    (wait_q == drop_wait_in - 32'd1);
  assign reg_free = !full || pkt_out_rdy_in || drop_now;
  assign accept   = !reset && reg_free && any_vld;

  assign pkt_in_rdy_out = accept ? grant : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    fwd_d   = fwd_q + {31'd0, deliver};
    drop_d  = drop_q + {31'd0, drop_now};
    if (accept) begin
      state_d = OutFull;
      data_d  = sel_data;
      ptr_d   = (grant_idx == PtrW'(NUM_INPUTS - 1)) ? '0 : grant_idx + PtrW'(1);
      wait_d  = '0;
    end else if (deliver || drop_now) begin
      state_d = OutEmpty;
      wait_d  = '0;
    end else if (full) begin
      wait_d  = wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OutEmpty;
      data_q  <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
      fwd_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

  assign pkt_out_vld_out  = full;
  assign pkt_out_data_out = data_q;
  assign fwd_cnt_out      = fwd_q;
  assign drop_cnt_out     = drop_q;

endmodule

// File: tb/tb_pkt_arbiter.sv
// Bench for pkt_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model.
module tb_pkt_arbiter;

  localparam int PB = 72;
  localparam int N  = 4;

  logic            clk_tb = 1'b0;
  logic            reset_tb;
  logic [31:0]     dw_tb;
  logic [N*PB-1:0] pkt_data_tb;
  logic [N-1:0]    vld_tb;
  logic [N-1:0]    in_rdy;
  logic [PB-1:0]   out_data;
  logic            out_vld;
  logic            out_rdy_tb;
  logic [31:0]     fwd_cnt;
  logic [31:0]     drop_cnt;

  logic [PB-1:0]   pkt [N];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_full;
  logic [PB-1:0] m_data;
  int          m_ptr;
  logic [31:0] m_wait, m_fwd, m_drop;
  bit          s_acc, s_deliver, s_dropnow;
  int          s_g;

  always #5 clk_tb = ~clk_tb;

  always_comb begin
    for (int i = 0; i < N; i++) pkt_data_tb[i*PB +: PB] = pkt[i];
  end

  pkt_arbiter #(
    .PACKET_BITS(PB),
    .NUM_INPUTS (N)
  ) dut (
    .clk             (clk_tb),
    .reset           (reset_tb),
    .drop_wait_in    (dw_tb),
    .pkt_in_data_in  (pkt_data_tb),
    .pkt_in_vld_in   (vld_tb),
    .pkt_in_rdy_out  (in_rdy),
    .pkt_out_data_out(out_data),
    .pkt_out_vld_out (out_vld),
    .pkt_out_rdy_in  (out_rdy_tb),
    .fwd_cnt_out     (fwd_cnt),
    .drop_cnt_out    (drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_pkts();
    logic [95:0] t;
    for (int i = 0; i < N; i++) begin
      t = {$urandom(), $urandom(), $urandom()};
      pkt[i] = t[PB-1:0];
    end
  endtask

  // Check outputs on the falling edge and decide what the next edge does.
  task automatic sample();
    bit free;
    logic [N-1:0] exp_rdy;
    @(negedge clk_tb);
    s_dropnow = m_full && !out_rdy_tb && (dw_tb != 0) && (m_wait == dw_tb - 32'd1);
    s_deliver = m_full && out_rdy_tb;
    free      = !m_full || out_rdy_tb || s_dropnow;
    s_g       = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (s_g < 0 && vld_tb[j]) s_g = j;
    end
    s_acc   = !reset_tb && free && (s_g >= 0);
    exp_rdy = s_acc ? (4'b0001 << s_g) : 4'b0000;
    chk("in_rdy", 128'(in_rdy), 128'(exp_rdy));
    chk("out_vld", 128'(out_vld), 128'(m_full));
    if (m_full) chk("out_data", 128'(out_data), 128'(m_data));
    chk("fwd_cnt", 128'(fwd_cnt), 128'(m_fwd));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
  endtask

  task automatic advance();
    if (reset_tb) begin
      m_full = 0; m_data = '0; m_ptr = 0; m_wait = 0; m_fwd = 0; m_drop = 0;
    end else begin
      if (s_acc) begin
        m_full = 1; m_data = pkt[s_g]; m_ptr = (s_g + 1) % N; m_wait = 0;
      end else if (s_deliver || s_dropnow) begin
        m_full = 0; m_wait = 0;
      end else if (m_full) begin
        m_wait = m_wait + 32'd1;
      end
      if (s_deliver) m_fwd = m_fwd + 32'd1;
      if (s_dropnow) m_drop = m_drop + 32'd1;
    end
    @(posedge clk_tb);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset_tb = 1'b1;
    cyc();
    reset_tb = 1'b0;
  endtask

  initial begin
    reset_tb = 1'b1; dw_tb = '0; vld_tb = '0; out_rdy_tb = 1'b0;
    for (int i = 0; i < N; i++) pkt[i] = '0;
    m_full = 0; m_data = '0; m_ptr = 0; m_wait = 0; m_fwd = 0; m_drop = 0;
    @(posedge clk_tb);
    #1;
    // Reset state
    sample();
    chk("rst_data", 128'(out_data), 128'(0));
    advance();
    reset_tb = 1'b0;

    // All requesters valid, sink always ready: strict rotation and full throughput
    vld_tb = 4'b1111; out_rdy_tb = 1'b1; dw_tb = 0;
    for (int c = 0; c < 9; c++) begin
      logic [3:0] e;
      rand_pkts();
      sample();
      e = 4'b0001 << (c % 4);
      chk("rr_grant", 128'(in_rdy), 128'(e));
      advance();
    end
    vld_tb = 4'b0000;
    sample();
    chk("rr_fwd8", 128'(fwd_cnt), 128'(8));
    advance();

    // Only requester 2 valid: accepted every cycle
    vld_tb = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      rand_pkts();
      sample();
      chk("only2", 128'(in_rdy), 128'(4'b0100));
      advance();
    end
    vld_tb = 4'b1111;
    sample();
    chk("ptr_after2", 128'(in_rdy), 128'(4'b1000));
    advance();

    // Timeout drops with a permanently stalled sink
    vld_tb = 4'b0000;
    do_reset();
    dw_tb = 4; out_rdy_tb = 1'b0; vld_tb = 4'b0001;
    for (int c = 0; c < 13; c++) begin
      rand_pkts();
      cyc();
    end
    sample();
    chk("to_drop3", 128'(drop_cnt), 128'(3));
    chk("to_fwd0", 128'(fwd_cnt), 128'(0));
    advance();

    // Ready arrives on the cycle the timeout would fire: delivery wins
    vld_tb = 4'b0000;
    do_reset();
    dw_tb = 4; out_rdy_tb = 1'b0; vld_tb = 4'b0001;
    rand_pkts();
    cyc();
    vld_tb = 4'b0000;
    for (int c = 0; c < 3; c++) cyc();
    out_rdy_tb = 1'b1;
    cyc();
    sample();
    chk("race_fwd1", 128'(fwd_cnt), 128'(1));
    chk("race_drop0", 128'(drop_cnt), 128'(0));
    advance();

    // Requesters 1 and 3 with a toggling sink
    do_reset();
    dw_tb = 0; vld_tb = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      out_rdy_tb = c[0];
      rand_pkts();
      cyc();
    end

    // Reset while holding a packet with ptr at 2
    vld_tb = 4'b0000;
    do_reset();
    out_rdy_tb = 1'b0; vld_tb = 4'b0010;
    rand_pkts();
    cyc();
    vld_tb = 4'b0101; reset_tb = 1'b1;
    sample();
    chk("rst_rdy0", 128'(in_rdy), 128'(0));
    advance();
    reset_tb = 1'b0;
    sample();
    chk("rst_vld0", 128'(out_vld), 128'(0));
    chk("rst_fwd0", 128'(fwd_cnt), 128'(0));
    chk("rst_drop0", 128'(drop_cnt), 128'(0));
    chk("rst_ptr0", 128'(in_rdy), 128'(4'b0001));
    advance();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      vld_tb = 4'($urandom_range(0, 15));
      out_rdy_tb = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) dw_tb = $urandom_range(0, 5);
      reset_tb = ($urandom_range(0, 99) == 0);
      rand_pkts();
      cyc();
    end
    reset_tb = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
